fetch_unit_q: RTL

//  Parametrised instruction fetch unit with a decoupled fetch queue.

---
 rtl/fetch_unit_q.sv | 109 ++++++++++
 1 files changed

// File: rtl/fetch_unit_q.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_unit_q
// Description : Sequential instruction fetch into a decoupled {pc, inst} queue,
//               with redirect/flush and halt-opcode detection.
// Revision    : 1.0
// ============================================================================
module fetch_unit_q #(
  parameter int               XLEN        = 32,
  parameter int               IMEM_DEPTH  = 1024,
  parameter int               FQ_DEPTH    = 4,
  parameter logic [5:0]       HALT_OPCODE = 6'h11,
  parameter logic [XLEN-1:0]  RESET_PC    = '0,
  localparam int              IDX_W       = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [IDX_W-1:0]  imem_addr,
  input  logic [XLEN-1:0]   imem_rdata,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_inst,
  output logic [XLEN-1:0]   out_pc,
  output logic              halted
);

  localparam int              PTR_W   = $clog2(FQ_DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W+1)'(FQ_DEPTH);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  inflight_pc;
  logic             inflight;
  logic             squash;
  logic             halt_seen;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [XLEN-1:0]  q_inst [FQ_DEPTH];
  logic [XLEN-1:0]  q_pc   [FQ_DEPTH];

  logic             push;
  logic             pop;
  logic             halt_push;
  logic [CNT_W:0]   occupancy;
  logic [XLEN-1:0]  redirect_target;

  assign redirect_target = redirect_pc & ~XLEN'(3);
  assign occupancy       = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
  assign push            = inflight & ~squash & ~redirect_valid;
  assign halt_push       = push & (imem_rdata[31:26] == HALT_OPCODE);
  assign out_valid       = (count != '0);
  assign pop             = out_valid & out_ready & ~redirect_valid;

  // The halt response itself blocks issue so nothing is fetched past it.
  assign imem_req  = rst & ~halt_seen & ~redirect_valid & ~halt_push & (occupancy < DEPTH_C);
  assign imem_addr = fetch_pc[IDX_W+1:2];

  assign out_inst  = out_valid ? q_inst[head] : '0;
  assign out_pc    = out_valid ? q_pc[head]   : '0;
  assign halted    = halt_seen & ~out_valid & ~inflight;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      squash      <= 1'b0;
      halt_seen   <= 1'b0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
    end else if (redirect_valid) begin
      fetch_pc  <= redirect_target;
      squash    <= inflight;
      inflight  <= 1'b0;
      halt_seen <= 1'b0;
      count     <= '0;
      head      <= '0;
      tail      <= '0;
    end else begin
      squash   <= 1'b0;
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(4);
      end
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      if (halt_push) halt_seen <= 1'b1;
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[tail] <= imem_rdata;
      q_pc[tail]   <= inflight_pc;
    end
  end

endmodule
`default_nettype wire
